// File: rtl/conv_phase_center_loader_if.sv
// Bus between the software command registers / datapath and the phase-center loader.
// The master side drives commands and the write grant; the slave (loader) drives the RAM port and status.
interface conv_phase_center_loader_if #(
   parameter int CH_W = 8,
   parameter int DW   = 16
);
   logic [31:0]     cmd_in;
   logic [31:0]     data_in;
   logic            wr_ok;
   logic            ram_we;
   logic [CH_W-1:0] ram_addr;
   logic [DW-1:0]   ram_din;
   logic            busy;
   logic [15:0]     load_count;
   logic            err_overrun;

   modport master (
      output cmd_in, data_in, wr_ok,
      input  ram_we, ram_addr, ram_din, busy, load_count, err_overrun
   );

   modport slave (
      input  cmd_in, data_in, wr_ok,
      output ram_we, ram_addr, ram_din, busy, load_count, err_overrun
   );
endinterface

// File: rtl/conv_phase_center_loader.sv
// Turns edges on the load_centers command register into single center-RAM writes or a full zero sweep.
// Define CENTER_CLEAR_EN to build the clear_all sweep; without it cmd_in[30] is ignored.
module conv_phase_center_loader #(
   parameter int NCH  = 256,
   parameter int CH_W = 8,
   parameter int DW   = 16
) (
   input logic                   user_clk,
   input logic                   user_rst,
   conv_phase_center_loader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SLOT
`ifdef CENTER_CLEAR_EN
      , CLEAR
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      cmd_d_q;
   logic [CH_W-1:0] addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [15:0]     count_q, count_d;
   logic            err_q, err_d;
   logic [CH_W-1:0] hold_addr_q;
   logic [DW-1:0]   hold_din_q;
   logic            go_edge, clear_edge, overrun;
   logic            ram_we;
   logic [CH_W-1:0] ram_addr;
   logic [DW-1:0]   ram_din;
   logic            unused_bits;

   assign go_edge = bus.cmd_in[31] & ~cmd_d_q[1];
`ifdef CENTER_CLEAR_EN
   logic [CH_W-1:0] sweep_q, sweep_d;
   assign clear_edge = bus.cmd_in[30] & ~cmd_d_q[0];
`else
   assign clear_edge = 1'b0;
`endif

   assign unused_bits = ^{bus.cmd_in, bus.data_in, cmd_d_q};

   // Edge history loads even during reset so a command held through reset produces no edge.
   always_ff @(posedge user_clk) begin
      cmd_d_q <= bus.cmd_in[31:30];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         hold_addr_q <= '0;
         hold_din_q  <= '0;
`ifdef CENTER_CLEAR_EN
         sweep_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         count_q     <= count_d;
         err_q       <= err_d;
         hold_addr_q <= ram_addr;
         hold_din_q  <= ram_din;
`ifdef CENTER_CLEAR_EN
         sweep_q     <= sweep_d;
`endif
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      din_d    = din_q;
      count_d  = count_q;
      overrun  = 1'b0;
      ram_we   = 1'b0;
      ram_addr = hold_addr_q;
      ram_din  = hold_din_q;
`ifdef CENTER_CLEAR_EN
      sweep_d  = sweep_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef CENTER_CLEAR_EN
            if (clear_edge) begin
               sweep_d = '0;
               state_d = CLEAR;
               overrun = go_edge;
            end else
`endif
            if (go_edge) begin
               addr_d  = bus.cmd_in[CH_W-1:0];
               din_d   = bus.data_in[DW-1:0];
               state_d = WAIT_SLOT;
            end
         end
         WAIT_SLOT: begin
            ram_we   = bus.wr_ok;
            ram_addr = addr_q;
            ram_din  = din_q;
            overrun  = go_edge | clear_edge;
            if (bus.wr_ok) begin
               count_d = count_q + 16'd1;
               state_d = IDLE;
            end
         end
`ifdef CENTER_CLEAR_EN
         CLEAR: begin
            ram_we   = bus.wr_ok;
            ram_addr = sweep_q;
            ram_din  = '0;
            overrun  = go_edge | clear_edge;
            if (bus.wr_ok) begin
               if (sweep_q == CH_W'(NCH - 1)) state_d = IDLE;
               else                           sweep_d = sweep_q + 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // A dropped edge outranks a same-cycle err_clr.
      err_d = overrun ? 1'b1 : (bus.cmd_in[29] ? 1'b0 : err_q);
   end

   assign bus.ram_we      = ram_we;
   assign bus.ram_addr    = ram_addr;
   assign bus.ram_din     = ram_din;
   assign bus.busy        = (state_q != IDLE);
   assign bus.load_count  = count_q;
   assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_conv_phase_center_loader.sv
// Bench for conv_phase_center_loader: queue-of-pending-writes reference model plus directed literal checks.
// Follows CENTER_CLEAR_EN the same way the design does.
module tb_conv_phase_center_loader;
   localparam int NCH  = 256;
   localparam int CH_W = 8;
   localparam int DW   = 16;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   conv_phase_center_loader_if #(.CH_W(CH_W), .DW(DW)) bus ();

   conv_phase_center_loader #(.NCH(NCH), .CH_W(CH_W), .DW(DW)) dut (
      .user_clk (clk),
      .user_rst (rst),
      .bus      (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the work still owed to the RAM, as a queue of pending writes.
   typedef struct packed {
      logic [CH_W-1:0] addr;
      logic [DW-1:0]   data;
      logic            single;
   } wr_t;

   wr_t             mq[$];
   logic [CH_W-1:0] m_last_addr;
   logic [DW-1:0]   m_last_din;
   logic [15:0]     m_count;
   logic            m_err;
   logic [1:0]      m_prev;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_last_addr = '0;
         m_last_din  = '0;
         m_count     = '0;
         m_err       = 1'b0;
         m_prev      = bus.cmd_in[31:30];
      end else begin
         bit go, clr, ovr, was_busy;
         go       = bus.cmd_in[31] && !m_prev[1];
`ifdef CENTER_CLEAR_EN
         clr      = bus.cmd_in[30] && !m_prev[0];
`else
         clr      = 1'b0;
`endif
         ovr      = 1'b0;
         was_busy = (mq.size() != 0);
         if (was_busy) begin
            m_last_addr = mq[0].addr;
            m_last_din  = mq[0].data;
            if (bus.wr_ok) begin
               if (mq[0].single) m_count = m_count + 16'd1;
               void'(mq.pop_front());
            end
            if (go || clr) ovr = 1'b1;
         end else if (clr) begin
            for (int a = 0; a < NCH; a++) mq.push_back(wr_t'{CH_W'(a), DW'(0), 1'b0});
            if (go) ovr = 1'b1;
         end else if (go) begin
            mq.push_back(wr_t'{bus.cmd_in[CH_W-1:0], bus.data_in[DW-1:0], 1'b1});
         end
         if (ovr) m_err = 1'b1;
         else if (bus.cmd_in[29]) m_err = 1'b0;
         m_prev = bus.cmd_in[31:30];
      end
   end

   logic            e_we;
   logic [CH_W-1:0] e_addr;
   logic [DW-1:0]   e_din;

   always @(negedge clk) begin
      if (chk_en) begin
         if (mq.size() != 0) begin
            e_we   = bus.wr_ok;
            e_addr = mq[0].addr;
            e_din  = mq[0].data;
         end else begin
            e_we   = 1'b0;
            e_addr = m_last_addr;
            e_din  = m_last_din;
         end
         check("ram_we",      32'(bus.ram_we),      32'(e_we));
         check("ram_addr",    32'(bus.ram_addr),    32'(e_addr));
         check("ram_din",     32'(bus.ram_din),     32'(e_din));
         check("busy",        32'(bus.busy),        32'(mq.size() != 0));
         check("load_count",  32'(bus.load_count),  32'(m_count));
         check("err_overrun", 32'(bus.err_overrun), 32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_cmd(input bit go, input bit clr, input bit ec, input logic [CH_W-1:0] ch);
      return {go, clr, ec, 21'b0, ch};
   endfunction

   int busy_cnt, we_cnt, exp_addr;
   bit go_lvl, clr_lvl;

   initial begin
      rst = 1'b1;
      bus.cmd_in = '0;
      bus.data_in = '0;
      bus.wr_ok = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      @(negedge clk);
      check("rst_we",    32'(bus.ram_we),      32'd0);
      check("rst_addr",  32'(bus.ram_addr),    32'd0);
      check("rst_din",   32'(bus.ram_din),     32'd0);
      check("rst_busy",  32'(bus.busy),        32'd0);
      check("rst_count", 32'(bus.load_count),  32'd0);
      check("rst_err",   32'(bus.err_overrun), 32'd0);
      step(); rst = 1'b0;

      // Single load to channel 5
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd5); bus.data_in = 32'h0000_1234; bus.wr_ok = 1'b1;
      @(negedge clk); check("single_t_we", 32'(bus.ram_we), 32'd0);
      step(); bus.cmd_in = '0;
      @(negedge clk);
      check("single_we",   32'(bus.ram_we),   32'd1);
      check("single_addr", 32'(bus.ram_addr), 32'd5);
      check("single_din",  32'(bus.ram_din),  32'h1234);
      check("single_busy", 32'(bus.busy),     32'd1);
      step();
      @(negedge clk);
      check("single_idle",  32'(bus.busy),       32'd0);
      check("single_count", 32'(bus.load_count), 32'd1);
      check("single_hold",  32'(bus.ram_addr),   32'd5);

      // Stalled slot on channel 255
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd255); bus.data_in = 32'h0000_8001; bus.wr_ok = 1'b0;
      busy_cnt = 0; we_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step(); bus.cmd_in = '0; bus.wr_ok = (i >= 10);
         @(negedge clk);
         busy_cnt += int'(bus.busy);
         we_cnt   += int'(bus.ram_we);
         if (i == 10) check("stall_addr", 32'(bus.ram_addr), 32'd255);
      end
      check("stall_busy",  32'(busy_cnt), 32'd11);
      check("stall_we",    32'(we_cnt),   32'd1);
      check("stall_count", 32'(bus.load_count), 32'd2);

      // Overrun while waiting for a slot
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd3); bus.data_in = 32'h0000_0333; bus.wr_ok = 1'b0;
      step(); bus.cmd_in = '0;
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd9); bus.data_in = 32'h0000_0999;
      step(); bus.cmd_in = '0; bus.wr_ok = 1'b1;
      @(negedge clk);
      check("ovr_we",   32'(bus.ram_we),   32'd1);
      check("ovr_addr", 32'(bus.ram_addr), 32'd3);
      we_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(); @(negedge clk); we_cnt += int'(bus.ram_we);
      end
      check("ovr_nowr", 32'(we_cnt), 32'd0);
      check("ovr_err",  32'(bus.err_overrun), 32'd1);
      step(); bus.cmd_in = mk_cmd(0, 0, 1, 8'd0);
      step(); bus.cmd_in = '0;
      @(negedge clk); check("ovr_errclr", 32'(bus.err_overrun), 32'd0);

      // Simultaneous go and clear edges
      step(); bus.cmd_in = mk_cmd(1, 1, 0, 8'd7); bus.data_in = 32'h0000_BEEF; bus.wr_ok = 1'b1;
      we_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step(); bus.cmd_in = '0;
         @(negedge clk); we_cnt += int'(bus.ram_we);
      end
`ifdef CENTER_CLEAR_EN
      check("both_we",    32'(we_cnt),             32'd256);
      check("both_err",   32'(bus.err_overrun),    32'd1);
      check("both_count", 32'(bus.load_count),     32'd3);
`else
      check("both_we",    32'(we_cnt),             32'd1);
      check("both_err",   32'(bus.err_overrun),    32'd0);
      check("both_count", 32'(bus.load_count),     32'd4);
`endif
      step(); bus.cmd_in = mk_cmd(0, 0, 1, 8'd0);
      step(); bus.cmd_in = '0;

`ifdef CENTER_CLEAR_EN
      // Clear sweep with wr_ok toggling 1,0
      step(); bus.cmd_in = mk_cmd(0, 1, 0, 8'd0);
      busy_cnt = 0; we_cnt = 0; exp_addr = 0;
      for (int i = 0; i < 600; i++) begin
         step(); bus.cmd_in = '0; bus.wr_ok = (i % 2 == 0);
         @(negedge clk);
         busy_cnt += int'(bus.busy);
         if (bus.ram_we) begin
            check("sweep_addr", 32'(bus.ram_addr), 32'(exp_addr));
            check("sweep_din",  32'(bus.ram_din),  32'd0);
            exp_addr++;
            we_cnt++;
         end
      end
      check("sweep_busy",  32'(busy_cnt), 32'd511);
      check("sweep_we",    32'(we_cnt),   32'd256);
      check("sweep_count", 32'(bus.load_count), 32'd3);
`endif

      // Randomized traffic
      go_lvl = 1'b0; clr_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         int r;
         step();
         r = int'($urandom_range(0, 99));
         if (r < 15) go_lvl = ~go_lvl;
         if (r == 50) clr_lvl = ~clr_lvl;
         bus.wr_ok   = ($urandom_range(0, 3) != 0);
         bus.data_in = $urandom;
         bus.cmd_in  = mk_cmd(go_lvl, clr_lvl, ($urandom_range(0, 29) == 0), CH_W'($urandom));
         rst         = ($urandom_range(0, 1999) == 0);
      end
      step(); rst = 1'b0; bus.cmd_in = '0; bus.wr_ok = 1'b1;
      for (int i = 0; i < 300; i++) step();
      bus.cmd_in = mk_cmd(0, 0, 1, 8'd0);
      step(); bus.cmd_in = '0;
      // Guarantee a nonzero load_count before the reset test
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd1);
      step(); bus.cmd_in = '0;
      step();

      // Reset mid-operation with go held high through reset
`ifdef CENTER_CLEAR_EN
      step(); bus.cmd_in = mk_cmd(0, 1, 0, 8'd0); bus.wr_ok = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         step(); bus.cmd_in = '0;
      end
      @(negedge clk);
      check("mid_addr", 32'(bus.ram_addr), 32'd100);
      check("mid_we",   32'(bus.ram_we),   32'd1);
`else
      step(); bus.cmd_in = mk_cmd(1, 0, 0, 8'd100); bus.data_in = 32'h0000_5A5A; bus.wr_ok = 1'b0;
      step(); bus.cmd_in = '0;
      @(negedge clk); check("mid_busy", 32'(bus.busy), 32'd1);
      step(); bus.wr_ok = 1'b1;
`endif
      step(); rst = 1'b1; bus.cmd_in = mk_cmd(1, 0, 0, 8'd42);
      step();
      @(negedge clk);
      check("rst2_we",    32'(bus.ram_we),     32'd0);
      check("rst2_addr",  32'(bus.ram_addr),   32'd0);
      check("rst2_din",   32'(bus.ram_din),    32'd0);
      check("rst2_busy",  32'(bus.busy),       32'd0);
      check("rst2_count", 32'(bus.load_count), 32'd0);
      step(); step(); rst = 1'b0;
      we_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(); @(negedge clk);
         we_cnt   += int'(bus.ram_we);
         busy_cnt += int'(bus.busy);
      end
      check("post_rst_we",   32'(we_cnt),   32'd0);
      check("post_rst_busy", 32'(busy_cnt), 32'd0);
      check("post_rst_err",  32'(bus.err_overrun), 32'd0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
